hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard logic: tracks destination registers of long-latency functional units (MUL/DIV, FPU) that complete out of the 5-stage timing.
- Issue happens at the ID->EX boundary; completion comes from a per-unit done/ack handshake.
- Generates read-after-write (RAW), write-after-write (WAW) and unit-busy stalls, and arbitrates unit writeback against the main pipeline's writeback.
- Each entry carries a watchdog counter; a stuck unit raises a sticky error.

---
 rtl/hazard_scoreboard_pkg.sv | 32 +++
 rtl/hazard_scoreboard_if.sv | 52 +++++
 rtl/hazard_scoreboard_sb_entry.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 152 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the long-latency hazard scoreboard.
package hazard_sb_pkg;

  // Register file selector carried with every register index.
  typedef enum logic {
    RF_INT = 1'b0,
    RF_FP  = 1'b1
  } rf_sel_e;

  // stall_cause bit positions.
  localparam int unsigned CAUSE_RAW = 0;
  localparam int unsigned CAUSE_WAW = 1;
  localparam int unsigned CAUSE_FU  = 2;
  localparam int unsigned CAUSE_W   = 3;

  // Unit ids of the default two-unit configuration.
  localparam int unsigned FU_MULDIV = 0;
  localparam int unsigned FU_FPU    = 1;

  // Entry fields are sized for the largest supported configuration;
  // instances zero-extend into them and the top truncates back.
  localparam int unsigned SB_RD_MAX_W  = 8;
  localparam int unsigned SB_CNT_MAX_W = 16;

  typedef struct packed {
    logic                    valid;
    logic [SB_RD_MAX_W-1:0]  rd;
    rf_sel_e                 fp;
    logic [SB_CNT_MAX_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Scoreboard bus: ID issue/source info, unit done/ack handshake, writeback,
// stall and error outputs. master = pipeline side, slave = scoreboard.
interface hazard_sb_if
  import hazard_sb_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_FU     = 2
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam int unsigned FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_en;
  logic                  id_rs2_en;
  logic                  id_rs1_fp;
  logic                  id_rs2_fp;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_en;
  logic                  id_rd_fp;
  logic                  id_fu_en;
  logic [FU_W-1:0]       id_fu;
  logic                  ex_flush;
  logic                  pipe_wb_en;
  logic [NUM_FU-1:0]     fu_done;
  logic [NUM_FU-1:0]     fu_ack;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_fp;
  logic                  stall;
  logic [CAUSE_W-1:0]    stall_cause;
  logic [NUM_REGS-1:0]   busy_int;
  logic [NUM_REGS-1:0]   busy_fp;
  logic                  timeout_err;
  logic [FU_W-1:0]       err_fu;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rs1_fp, id_rs2_fp,
           id_rd, id_rd_en, id_rd_fp, id_fu_en, id_fu, ex_flush, pipe_wb_en, fu_done,
    input  fu_ack, wb_valid, wb_rd, wb_fp, stall, stall_cause, busy_int, busy_fp,
           timeout_err, err_fu
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rs1_fp, id_rs2_fp,
           id_rd, id_rd_en, id_rd_fp, id_fu_en, id_fu, ex_flush, pipe_wb_en, fu_done,
    output fu_ack, wb_valid, wb_rd, wb_fp, stall, stall_cause, busy_int, busy_fp,
           timeout_err, err_fu
  );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry with its watchdog counter.
// Ports: clk, rst (async high), issue/ack strobes, issue_rd/issue_fp payload,
// entry (current state), timeout_c (valid entry whose counter reached 0).
module sb_entry
  import hazard_sb_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_LAT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic                  ack,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_fp,
  output sb_entry_t             entry,
  output logic                  timeout_c
);
  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  fp_q;
  logic [CNT_W-1:0]      cnt_q;

  // Issue loads a fresh watchdog; an un-acked entry counts down to 0 and stays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      fp_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (issue) begin
      valid_q <= 1'b1;
      rd_q    <= issue_rd;
      fp_q    <= issue_fp;
      cnt_q   <= CNT_W'(MAX_LAT);
    end else if (ack) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (valid_q && (cnt_q != '0)) begin
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    entry.valid = valid_q;
    entry.rd    = SB_RD_MAX_W'(rd_q);
    entry.fp    = rf_sel_e'(fp_q);
    entry.cnt   = SB_CNT_MAX_W'(cnt_q);
  end

  assign timeout_c = valid_q && (cnt_q == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for long-latency units: RAW/WAW/unit-busy stall, unit
// writeback arbitration (main pipeline has priority), pending-write bitmaps,
// sticky watchdog error. Ports: clk, rst (async high), sb (slave modport).
module hazard_scoreboard
  import hazard_sb_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_FU     = 2,
  parameter int unsigned MAX_LAT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  hazard_sb_if.slave  sb
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam int unsigned FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  sb_entry_t             ent [NUM_FU];
  logic [NUM_FU-1:0]     tmo_c;
  logic [NUM_FU-1:0]     issue_c;
  logic [NUM_FU-1:0]     ack_c;
  logic [NUM_FU-1:0]     wr_en_q;
  logic [NUM_FU-1:0]     live_c;
  logic                  raw_c, waw_c, fu_busy_c, stall_c, issue_ok_c;
  logic                  wb_valid_c, wb_fp_c;
  logic [REG_ADDR_W-1:0] wb_rd_c;
  logic [NUM_REGS-1:0]   busy_int_c, busy_fp_c;
  logic                  tmo_any_c;
  logic [FU_W-1:0]       tmo_first_c;
  logic                  timeout_err_q;
  logic [FU_W-1:0]       err_fu_q;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_ent
    sb_entry #(.REG_ADDR_W(REG_ADDR_W), .MAX_LAT(MAX_LAT)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue_c[g]),
      .ack       (ack_c[g]),
      .issue_rd  (sb.id_rd),
      .issue_fp  (sb.id_rd_fp),
      .entry     (ent[g]),
      .timeout_c (tmo_c[g])
    );
    // Counter value and the padding of rd are not needed at this level.
    logic unused_ent;
    assign unused_ent = ^{ent[g].cnt, ent[g].rd};
  end

  // Entry slot also tracks whether it owes a register write at all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (issue_c[i]) wr_en_q[i] <= sb.id_rd_en;
      end
    end
  end

  // Hazard compare. Integer x0 is never a pending write, so it never matches.
  always_comb begin
    raw_c      = 1'b0;
    waw_c      = 1'b0;
    fu_busy_c  = 1'b0;
    live_c     = '0;
    busy_int_c = '0;
    busy_fp_c  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      live_c[i] = ent[i].valid && wr_en_q[i] &&
                  !((ent[i].fp == RF_INT) && (REG_ADDR_W'(ent[i].rd) == '0));
      if (live_c[i]) begin
        if (sb.id_rs1_en && (REG_ADDR_W'(ent[i].rd) == sb.id_rs1) &&
            (ent[i].fp == rf_sel_e'(sb.id_rs1_fp))) raw_c = 1'b1;
        if (sb.id_rs2_en && (REG_ADDR_W'(ent[i].rd) == sb.id_rs2) &&
            (ent[i].fp == rf_sel_e'(sb.id_rs2_fp))) raw_c = 1'b1;
        if (sb.id_rd_en && (REG_ADDR_W'(ent[i].rd) == sb.id_rd) &&
            (ent[i].fp == rf_sel_e'(sb.id_rd_fp))) waw_c = 1'b1;
        if (ent[i].fp == RF_FP) busy_fp_c[REG_ADDR_W'(ent[i].rd)]  = 1'b1;
        else                    busy_int_c[REG_ADDR_W'(ent[i].rd)] = 1'b1;
      end
      if (ent[i].valid && (sb.id_fu == FU_W'(i))) fu_busy_c = 1'b1;
    end
    raw_c      = raw_c && sb.id_valid;
    waw_c      = waw_c && sb.id_valid;
    fu_busy_c  = fu_busy_c && sb.id_valid && sb.id_fu_en;
    stall_c    = raw_c || waw_c || fu_busy_c;
    issue_ok_c = sb.id_valid && sb.id_fu_en && !stall_c && !sb.ex_flush;
    issue_c    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (sb.id_fu == FU_W'(i)) issue_c[i] = issue_ok_c;
    end
  end

  // Lowest-index completing unit wins unless the main pipeline writes back.
  always_comb begin
    ack_c      = '0;
    wb_valid_c = 1'b0;
    wb_rd_c    = '0;
    wb_fp_c    = 1'b0;
    if (!sb.pipe_wb_en) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!wb_valid_c && ent[i].valid && sb.fu_done[i]) begin
          ack_c[i]   = 1'b1;
          wb_valid_c = 1'b1;
          wb_rd_c    = REG_ADDR_W'(ent[i].rd);
          wb_fp_c    = (ent[i].fp == RF_FP);
        end
      end
    end
  end

  // First timing-out unit (lowest index on a tie).
  always_comb begin
    tmo_any_c   = 1'b0;
    tmo_first_c = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (tmo_c[i]) begin
        tmo_any_c   = 1'b1;
        tmo_first_c = FU_W'(i);
      end
    end
  end

  // Sticky error; err_fu keeps the first offender.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
      err_fu_q      <= '0;
    end else if (!timeout_err_q && tmo_any_c) begin
      timeout_err_q <= 1'b1;
      err_fu_q      <= tmo_first_c;
    end
  end

  always_comb begin
    sb.stall_cause            = '0;
    sb.stall_cause[CAUSE_RAW] = raw_c;
    sb.stall_cause[CAUSE_WAW] = waw_c;
    sb.stall_cause[CAUSE_FU]  = fu_busy_c;
  end

  assign sb.stall       = stall_c;
  assign sb.fu_ack      = ack_c;
  assign sb.wb_valid    = wb_valid_c;
  assign sb.wb_rd       = wb_rd_c;
  assign sb.wb_fp       = wb_fp_c;
  assign sb.busy_int    = busy_int_c;
  assign sb.busy_fp     = busy_fp_c;
  assign sb.timeout_err = timeout_err_q;
  assign sb.err_fu      = err_fu_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/100ps
module tb_hazard_scoreboard;
  import hazard_sb_pkg::*;

  localparam int unsigned RW = 5;
  localparam int unsigned NF = 2;

  typedef struct {
    logic [RW-1:0] rd;
    logic          fp;
    logic [NF-1:0] ack;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  wb_exp_t exp_q[$];

  hazard_sb_if #(.REG_ADDR_W(RW), .NUM_FU(NF)) sb_bus ();

  hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_FU(NF), .MAX_LAT(8)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    sb_bus.id_valid = 0; sb_bus.id_rs1 = 0; sb_bus.id_rs2 = 0;
    sb_bus.id_rs1_en = 0; sb_bus.id_rs2_en = 0; sb_bus.id_rs1_fp = 0; sb_bus.id_rs2_fp = 0;
    sb_bus.id_rd = 0; sb_bus.id_rd_en = 0; sb_bus.id_rd_fp = 0;
    sb_bus.id_fu_en = 0; sb_bus.id_fu = 0; sb_bus.ex_flush = 0;
  endtask

  task automatic issue(input int fu, input int rd, input logic fp);
    idle();
    sb_bus.id_valid = 1; sb_bus.id_fu_en = 1; sb_bus.id_fu = 1'(fu);
    sb_bus.id_rd = RW'(rd); sb_bus.id_rd_en = 1; sb_bus.id_rd_fp = fp;
  endtask

  task automatic read1(input int rs, input logic fp);
    idle();
    sb_bus.id_valid = 1; sb_bus.id_rs1 = RW'(rs); sb_bus.id_rs1_en = 1; sb_bus.id_rs1_fp = fp;
  endtask

  task automatic expect_wb(input int rd, input logic fp, input logic [NF-1:0] ack);
    wb_exp_t e;
    e.rd = RW'(rd); e.fp = fp; e.ack = ack;
    exp_q.push_back(e);
  endtask

  // Writeback monitor: every granted result must match the next expected one.
  always @(negedge clk) begin
    if (!rst && sb_bus.wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 64'(sb_bus.fu_ack), 64'(0));
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(sb_bus.wb_rd), 64'(e.rd));
        chk("wb_fp", 64'(sb_bus.wb_fp), 64'(e.fp));
        chk("wb_ack", 64'(sb_bus.fu_ack), 64'(e.ack));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle();
    sb_bus.pipe_wb_en = 0;
    sb_bus.fu_done = '0;
    #1;
    chk("rst_stall", 64'(sb_bus.stall), 64'(0));
    chk("rst_ack", 64'(sb_bus.fu_ack), 64'(0));
    chk("rst_wb_valid", 64'(sb_bus.wb_valid), 64'(0));
    chk("rst_busy_int", 64'(sb_bus.busy_int), 64'(0));
    chk("rst_busy_fp", 64'(sb_bus.busy_fp), 64'(0));
    chk("rst_tmo", 64'(sb_bus.timeout_err), 64'(0));
    chk("rst_err_fu", 64'(sb_bus.err_fu), 64'(0));
    tick(); tick();
    rst = 0;
    tick();

    // RAW: MUL x5 issued in cycle 0, reader from cycle 1, done in cycle 6.
    issue(FU_MULDIV, 5, 0);
    #1 chk("raw_c0_stall", 64'(sb_bus.stall), 64'(0));
    for (int c = 1; c <= 5; c++) begin
      tick(); read1(5, 0);
      #1 chk("raw_stall", 64'(sb_bus.stall), 64'(1));
      chk("raw_cause", 64'(sb_bus.stall_cause), 64'(3'b001));
    end
    chk("raw_busy_int", 64'(sb_bus.busy_int), 64'(32'h0000_0020));
    tick(); sb_bus.fu_done = 2'b01; expect_wb(5, 0, 2'b01);
    #1 chk("raw_c6_stall", 64'(sb_bus.stall), 64'(1));
    chk("raw_c6_ack", 64'(sb_bus.fu_ack), 64'(2'b01));
    tick(); sb_bus.fu_done = 2'b00;
    #1 chk("raw_c7_stall", 64'(sb_bus.stall), 64'(0));
    chk("raw_c7_busy", 64'(sb_bus.busy_int), 64'(0));

    // x0 / file separation with FPU f0 in flight.
    tick(); issue(FU_FPU, 0, 1);
    tick(); idle();
    sb_bus.id_valid = 1; sb_bus.id_rs1_en = 1; sb_bus.id_rs2_en = 1;
    #1 chk("x0_int_stall", 64'(sb_bus.stall), 64'(0));
    chk("f0_busy_fp", 64'(sb_bus.busy_fp), 64'(1));
    sb_bus.id_rs2_fp = 1;
    #1 chk("f0_fp_stall", 64'(sb_bus.stall), 64'(1));
    chk("f0_fp_cause", 64'(sb_bus.stall_cause), 64'(3'b001));
    tick(); idle(); sb_bus.fu_done = 2'b10; expect_wb(0, 1, 2'b10);
    tick(); sb_bus.fu_done = 2'b00;
    #1 chk("f0_clear", 64'(sb_bus.busy_fp), 64'(0));

    // Unit busy, then a flushed issue that must not create an entry.
    tick(); issue(FU_MULDIV, 7, 0);
    tick(); issue(FU_MULDIV, 9, 0);
    #1 chk("fu_busy_stall", 64'(sb_bus.stall), 64'(1));
    chk("fu_busy_cause", 64'(sb_bus.stall_cause), 64'(3'b100));
    tick(); issue(FU_FPU, 12, 1); sb_bus.ex_flush = 1;
    #1 chk("flush_nostall", 64'(sb_bus.stall), 64'(0));
    tick(); idle();
    #1 chk("flush_busy_fp", 64'(sb_bus.busy_fp), 64'(0));
    chk("flush_busy_int", 64'(sb_bus.busy_int), 64'(32'h0000_0080));
    sb_bus.fu_done = 2'b01; expect_wb(7, 0, 2'b01);
    tick(); sb_bus.fu_done = 2'b00;

    // Arbitration: both done while the pipeline writes back, then lowest first.
    tick(); issue(FU_MULDIV, 3, 0);
    tick(); issue(FU_FPU, 4, 1);
    tick(); idle(); sb_bus.fu_done = 2'b11; sb_bus.pipe_wb_en = 1;
    #1 chk("arb_pipe_ack", 64'(sb_bus.fu_ack), 64'(0));
    chk("arb_pipe_wbv", 64'(sb_bus.wb_valid), 64'(0));
    expect_wb(3, 0, 2'b01); expect_wb(4, 1, 2'b10);
    tick(); sb_bus.pipe_wb_en = 0;
    #1 chk("arb_c11_ack", 64'(sb_bus.fu_ack), 64'(2'b01));
    tick();
    #1 chk("arb_c12_ack", 64'(sb_bus.fu_ack), 64'(2'b10));
    tick();
    #1 chk("arb_c13_wbv", 64'(sb_bus.wb_valid), 64'(0));
    sb_bus.fu_done = 2'b00;

    // Watchdog on the FPU; a later MUL timeout must not move err_fu.
    chk("wd_pre_err", 64'(sb_bus.timeout_err), 64'(0));
    tick(); issue(FU_FPU, 20, 1);
    tick(); read1(20, 1);
    for (int c = 1; c <= 7; c++) tick();
    #1 chk("wd_early", 64'(sb_bus.timeout_err), 64'(0));
    tick(); tick();
    #1 chk("wd_err", 64'(sb_bus.timeout_err), 64'(1));
    chk("wd_err_fu", 64'(sb_bus.err_fu), 64'(1));
    chk("wd_stall_kept", 64'(sb_bus.stall), 64'(1));
    issue(FU_MULDIV, 21, 0);
    for (int c = 0; c < 12; c++) begin tick(); idle(); end
    read1(20, 1);
    #1 chk("wd_sticky", 64'(sb_bus.timeout_err), 64'(1));
    chk("wd_err_fu_kept", 64'(sb_bus.err_fu), 64'(1));
    chk("wd_two_busy", 64'({sb_bus.busy_fp[20], sb_bus.busy_int[21]}), 64'(2'b11));

    // Async reset between edges with both entries valid and done asserted.
    sb_bus.fu_done = 2'b11;
    #1 chk("ar_pre_ack", 64'(sb_bus.fu_ack), 64'(2'b01));
    rst = 1;
    #1 chk("ar_busy_int", 64'(sb_bus.busy_int), 64'(0));
    chk("ar_busy_fp", 64'(sb_bus.busy_fp), 64'(0));
    chk("ar_stall", 64'(sb_bus.stall), 64'(0));
    chk("ar_ack", 64'(sb_bus.fu_ack), 64'(0));
    chk("ar_tmo", 64'(sb_bus.timeout_err), 64'(0));
    tick(); rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1 chk("ar_no_wb", 64'({sb_bus.wb_valid, sb_bus.fu_ack}), 64'(0));
    end
    chk("ar_stall_after", 64'(sb_bus.stall), 64'(0));
    sb_bus.fu_done = 2'b00;
    tick();
    chk("wb_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
